seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle ALU.
- Executes the existing logic/arithmetic/shift operations in one registered cycle.
- Adds iterative multi-cycle unsigned multiply, divide and remainder.
- Sits between the decode/ALU-control stage and writeback in the multi-cycle CPU; holds its result until writeback accepts it.

---
 rtl/seq_alu.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with one-cycle logic/arith/shift ops and iterative unsigned MUL/DIVU/REMU.
// Define SEQ_ALU_DIV_EN to build the restoring divider (DIVU/REMU); otherwise those codes act as unknown ops.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             div0
);

  // Handshake: a request transfers on a rising clk edge with in_valid && in_ready; a result
  // transfers on a rising edge with out_valid && out_ready. Both sides hold their payload until then.

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
`endif

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   shamt;
  logic             sub;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] low_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic [WIDTH-1:0] mul_acc_next;

`ifdef SEQ_ALU_DIV_EN
  logic             div0_q;
  logic             is_rem;
  logic [WIDTH-1:0] rem;
  logic             is_div_op;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
`endif

  // Single-cycle datapath; also supplies the divide-by-zero results.
  always_comb begin
    shamt    = src2[SHW-1:0];
    sub      = (ALU_control == OP_SUB);
    b_in     = sub ? ~src2 : src2;
    add_full = {1'b0, src1} + {1'b0, b_in} + {{WIDTH{1'b0}}, sub};
    // Carry into the MSB, from the low WIDTH-1 bits alone.
    low_sum  = {1'b0, src1[WIDTH-2:0]} + {1'b0, b_in[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (ALU_control)
      OP_AND: alu_res = src1 & src2;
      OP_OR:  alu_res = src1 | src2;
      OP_XOR: alu_res = src1 ^ src2;
      OP_NOR: alu_res = ~(src1 | src2);
      OP_ADD, OP_SUB: begin
        alu_res  = add_full[WIDTH-1:0];
        alu_cout = add_full[WIDTH];
        alu_ovf  = low_sum[WIDTH-1] ^ add_full[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLL: alu_res = src1 << shamt;
      OP_SRL: alu_res = src1 >> shamt;
      OP_SRA: alu_res = $signed(src1) >>> shamt;
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = src1;
`endif
      default: alu_res = '0;
    endcase
    mul_acc_next = op_b[0] ? (acc + op_a) : acc;
  end

`ifdef SEQ_ALU_DIV_EN
  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    is_div_op    = (ALU_control == OP_DIVU) || (ALU_control == OP_REMU);
    rem_shift    = {rem, op_a[WIDTH-1]};
    trial        = rem_shift - {1'b0, op_b};
    ge           = ~trial[WIDTH];
    div_rem_next = ge ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    div_quo_next = {op_a[WIDTH-2:0], ge};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      cnt      <= '0;
`ifdef SEQ_ALU_DIV_EN
      div0_q   <= 1'b0;
      is_rem   <= 1'b0;
      rem      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            op_a   <= src1;
            op_b   <= src2;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_ALU_DIV_EN
            div0_q <= 1'b0;
            rem    <= '0;
            is_rem <= (ALU_control == OP_REMU);
`endif
            if (ALU_control == OP_MUL) begin
              state <= S_MUL;
`ifdef SEQ_ALU_DIV_EN
            end else if (is_div_op && (src2 != '0)) begin
              state <= S_DIV;
`endif
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              cout_q   <= alu_cout;
              ovf_q    <= alu_ovf;
`ifdef SEQ_ALU_DIV_EN
              div0_q   <= is_div_op;
`endif
              state    <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc  <= mul_acc_next;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            result_q <= mul_acc_next;
            zero_q   <= (mul_acc_next == '0);
            state    <= S_DONE;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          rem  <= div_rem_next;
          op_a <= div_quo_next;
          cnt  <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            result_q <= is_rem ? div_rem_next : div_quo_next;
            zero_q   <= is_rem ? (div_rem_next == '0) : (div_quo_next == '0);
            state    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_ready must read 0 while reset is held, even though the FSM already sits in IDLE.
  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
`ifdef SEQ_ALU_DIV_EN
  assign div0      = div0_q;
`else
  assign div0      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios plus random ops checked by a scoreboard against an arithmetic model.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alu_control = 4'd0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         in_ready, out_valid, zero, cout, overflow, div0;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;
  bit ov_prev = 1'b0;

  // Expected entry packs {result, zero, cout, overflow, div0}.
  logic [W+3:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  logic [W+3:0] mon_e;
  int           mon_l, mon_a;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_control(alu_control), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .cout(cout), .overflow(overflow), .div0(div0)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected results pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W+3:0] e, output int lat);
    logic [W-1:0] r;
    logic c, v, d;
    longint sa, sb, s;
    logic [4:0] sh;
    r = '0; c = 1'b0; v = 1'b0; d = 1'b0; lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = sa + sb;
        r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        r = a - b;
        c = (a >= b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0100: r = a << sh;
      4'b1000: r = a >> sh;
      4'b0101: r = 32'(sa >>> sh);
      4'b1001: begin r = 32'(64'(a) * 64'(b)); lat = 33; end
`ifdef SEQ_ALU_DIV_EN
      4'b1010: if (b == 0) begin r = '1; d = 1'b1; end else begin r = a / b; lat = 33; end
      4'b1011: if (b == 0) begin r = a;  d = 1'b1; end else begin r = a % b; lat = 33; end
`endif
      default: r = '0;
    endcase
    e = {r, (r == 0), c, v, d};
  endfunction

  // Driver: present a request at a negedge where in_ready is high, so the next edge accepts it.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+3:0] e;
    int l;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      return;
    end
    alu_control = op; src1 = a; src2 = b; in_valid = 1'b1;
    model(op, a, b, e, l);
    exp_q.push_back(e); lat_q.push_back(l); acc_q.push_back(cyc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom; alu_control = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_valid(output int ir_hi);
    int n;
    n = 0; ir_hi = 0;
    do begin
      @(negedge clk);
      if (in_ready) ir_hi++;
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: each new out_valid presentation is checked against the queue head.
  always @(negedge clk) begin
    if (!rst_n) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          mon_a = acc_q.pop_front();
          chk("result", result, mon_e[W+3:4]);
          chk("zero", zero, mon_e[3]);
          chk("cout", cout, mon_e[2]);
          chk("overflow", overflow, mon_e[1]);
          chk("div0", div0, mon_e[0]);
          chk("latency", cyc - mon_a, mon_l);
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int hi;
    logic [3:0] op;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_cout", cout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_div0", div0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1001, 32'h0001_0003, 32'h0000_0005);
    wait_valid(hi);
    chk("mul_in_ready_low", hi, 0);
    issue(4'b1010, 32'd100, 32'd7);
    issue(4'b1011, 32'd100, 32'd7);
    issue(4'b1010, 32'd1234, 32'd0);
    issue(4'b1011, 32'd1234, 32'd0);
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1);
    drain();

    // Backpressure: result held while out_ready stays low.
    out_ready = 1'b0;
    issue(4'b0101, 32'h8000_0000, 32'd4);
    wait_valid(hi);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 32'hF800_0000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    // Reset in the middle of a multiply discards it.
    issue(4'b1001, $urandom, $urandom);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 0);
    void'(exp_q.pop_back()); void'(lat_q.pop_back()); void'(acc_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    issue(4'b0010, 32'd2, 32'd3);
    drain();

    // Random traffic with random backpressure.
    rdy_rand = 1'b1;
    repeat (150) begin
      op = 4'($urandom_range(0, 15));
      issue(op, rnd_val(), rnd_val());
    end
    rdy_rand = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
